// File: rtl/jtag_reg_bank_if.sv
// JTAG register bank bus: TAP-side controls, shift data and bank outputs.
// Master drives TAP/test side, slave is the bank.
interface jtag_reg_bank_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8
);
  logic                       capture_dr;
  logic                       update_dr;
  logic                       extest_sel;
  logic [ADDR_W-1:0]          tcr_addr;
  logic                       tcr_wr;
  logic                       tcr_live;
  logic [DATA_W-1:0]          trcal_out;
  logic [NUM_REGS*DATA_W-1:0] status_i;
  logic [DATA_W-1:0]          trcal_in;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic [7:0]                 err_cnt;
  logic                       busy;

  modport master (
    output capture_dr, update_dr, extest_sel,
    output tcr_addr, tcr_wr, tcr_live,
    output trcal_out, status_i,
    input  trcal_in, reg_q, wr_strobe,
    input  err_cnt, busy
  );

  modport slave (
    input  capture_dr, update_dr, extest_sel,
    input  tcr_addr, tcr_wr, tcr_live,
    input  trcal_out, status_i,
    output trcal_in, reg_q, wr_strobe,
    output err_cnt, busy
  );
endinterface

// File: rtl/jtag_reg_bank.sv
// JTAG-accessible register bank in the system clock domain.
// TAP strobes are synchronised, edge-detected and turned into actions.
module jtag_reg_bank #(
  parameter int                   NUM_REGS      = 8,
  parameter int                   DATA_W        = 32,
  parameter int                   ADDR_W        = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK       = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL     = '0,
  parameter int                   DEBUG_ADDR    = 15,
  parameter logic [DATA_W-1:0]    DEBUG_PATTERN = 32'hDEAD_BEEF,
  parameter int                   SYNC_STAGES   = 2
) (
  input logic clk,
  input logic rst_n,
  jtag_reg_bank_if.slave bus
);

  logic [SYNC_STAGES-1:0] r_cap_s;
  logic [SYNC_STAGES-1:0] r_upd_s;
  logic                   r_cap_prev;
  logic                   r_upd_prev;
  logic                   r_pend;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic [DATA_W-1:0]      r_trcal;
  logic [NUM_REGS-1:0]    r_strobe;
  logic [7:0]             r_err;

  logic                   w_cap_p;
  logic                   w_upd_p;
  logic                   w_cap;
  logic                   w_upd;
  logic                   w_both;
  logic                   w_in_rng;
  logic                   w_ro;
  logic                   w_dbg;
  logic                   w_vrd;
  logic                   w_vwr;
  logic                   w_wr_ok;
  logic                   w_err;
  logic [NUM_REGS-1:0]    w_hot;
  logic [DATA_W-1:0]      w_sel;
  logic [NUM_REGS*DATA_W-1:0] w_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_s    <= '0;
      r_upd_s    <= '0;
      r_cap_prev <= 1'b0;
      r_upd_prev <= 1'b0;
    end else begin
      r_cap_s    <= {r_cap_s[SYNC_STAGES-2:0], bus.capture_dr};
      r_upd_s    <= {r_upd_s[SYNC_STAGES-2:0], bus.update_dr};
      r_cap_prev <= r_cap_s[SYNC_STAGES-1];
      r_upd_prev <= r_upd_s[SYNC_STAGES-1];
    end
  end

  assign w_cap_p = r_cap_s[SYNC_STAGES-1] & ~r_cap_prev;
  assign w_upd_p = r_upd_s[SYNC_STAGES-1] & ~r_upd_prev;

  // Coincident strobes: update now, capture deferred one cycle
  assign w_both = w_cap_p & w_upd_p & bus.extest_sel;
  assign w_upd  = w_upd_p & bus.extest_sel & bus.tcr_wr;
  assign w_cap  = bus.extest_sel &
                  ((w_cap_p & ~w_upd_p) | r_pend);

  always_comb begin
    w_in_rng = 1'b0;
    w_ro     = 1'b0;
    w_hot    = '0;
    w_sel    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.tcr_addr == ADDR_W'(i)) begin
        w_in_rng = 1'b1;
        w_ro     = RO_MASK[i];
        w_hot[i] = 1'b1;
        w_sel    = RO_MASK[i] ?
                   bus.status_i[i*DATA_W +: DATA_W] :
                   r_regs[i];
      end
    end
    w_dbg = (bus.tcr_addr == ADDR_W'(DEBUG_ADDR));
    if (w_dbg) begin
      w_sel = DEBUG_PATTERN;
    end
  end

  assign w_vrd   = w_in_rng | w_dbg;
  assign w_vwr   = w_in_rng & ~w_ro;
  assign w_wr_ok = w_upd & w_vwr;
  assign w_err   = (w_cap & ~w_vrd) | (w_upd & ~w_vwr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_strobe <= '0;
      r_pend   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && w_hot[i]) begin
          r_regs[i] <= bus.trcal_out;
        end
      end
      r_strobe <= w_wr_ok ? w_hot : '0;
      r_pend   <= w_both;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trcal <= '0;
      r_err   <= 8'h00;
    end else begin
      if (w_cap) begin
        r_trcal <= w_vrd ? w_sel : '0;
      end else if (bus.tcr_live) begin
        r_trcal <= w_sel;
      end
      if (w_err && r_err != 8'hFF) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  always_comb begin
    w_reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_q[i*DATA_W +: DATA_W] =
        RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign bus.trcal_in  = r_trcal;
  assign bus.reg_q     = w_reg_q;
  assign bus.wr_strobe = r_strobe;
  assign bus.err_cnt   = r_err;
  assign bus.busy      = (|r_cap_s) | (|r_upd_s) | r_pend;

endmodule
